bf_mac_drain: RTL
=================

Name: bf_mac_drain

Overview:
- Sits directly downstream of the bfloat16 MAC PE.
- Gates the PE's `mac_en` so that exactly `K_LEN` products are accumulated, then captures the fp32 accumulator.
- Rounds the captured value to bfloat16 (round-to-nearest-even), with optional ReLU, and pushes it into a small first-word-fall-through (FWFT) output FIFO.
- Pulses a clear back to the PE so the next dot product starts from zero.

Parameters:
- K_LEN, 16, number of accepted MAC beats per dot product (>=1).
- DEPTH, 4, output FIFO depth in entries (power of 2, >=2).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  upstream has an operand pair for the PE.
- in_ready  output  1  drain accepts a beat. PE `mac_en` = `in_valid & in_ready`.
- acc_result  input  32  fp32 accumulator from the PE, registered.
- relu_en  input  1  apply ReLU on capture; sampled in CAPTURE.
- acc_clr  output  1  one-cycle clear pulse. ORed with `rst` into the PE's synchronous reset.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer pops when `out_valid & out_ready`.
- out_data  output  16  bf16 result at FIFO head.
- out_flags  output  2  [1] = NaN, [0] = ±inf, for the head entry.
- fifo_full  output  1  FIFO holds DEPTH entries.
- beat_cnt  output  $clog2(K_LEN+1)  beats accepted in the current dot product.

Behaviour:
- Reset (async, any state):
  - state = ACCUM; `beat_cnt` = 0; FIFO emptied.
  - `acc_clr` = 0, `out_valid` = 0, `out_data` = 0, `out_flags` = 0, `fifo_full` = 0.
  - `in_ready` = 1 once reset is released.
  - Reset mid-vector discards the partial count and all FIFO contents.
- State machine:
  - ACCUM:
    - `in_ready` = 1.
    - Each cycle with `in_valid` = 1, `beat_cnt` increments.
    - The beat that makes `beat_cnt` reach K_LEN moves the state to CAPTURE at the same edge. `beat_cnt` is then held at K_LEN.
  - CAPTURE:
    - `in_ready` = 0. `acc_result` already includes the last product, since the PE registers at the same edge.
    - If FIFO not full: write converted value at the edge, go to CLEAR.
    - If FIFO full: stay in CAPTURE and hold, with no drop and no overwrite.
    - A pop in the same cycle does not free space until the next cycle; push is gated on registered full only.
  - CLEAR:
    - `in_ready` = 0; `acc_clr` = 1 for exactly this cycle.
    - Next edge: ACCUM, `beat_cnt` = 0.
  - Per-vector overhead: 2 cycles minimum (CAPTURE + CLEAR) when the FIFO is not full.
- fp32->bf16 conversion (combinational, CAPTURE only). Let e = `acc_result[30:23]`, m = `acc_result[22:0]`:
  - NaN (e=FF, m!=0) -> 16'h7FC0, flags = 2'b10. ReLU does not alter NaN.
  - Inf (e=FF, m=0) -> {s, 8'hFF, 7'h0}, flags = 2'b01.
  - e=0 (zero/denormal) -> {s, 15'h0}, flush to signed zero.
  - Otherwise: r = `acc_result` + 32'h7FFF + `acc_result[16]`, result = r[31:16].
    - Carry into exponent FF yields ±inf; flags = 2'b01 in that case.
  - ReLU (`relu_en` = 1): any non-NaN value with s = 1 (including -0 and -inf) -> 16'h0000, flags = 0.
- FIFO:
  - Pointers of $clog2(DEPTH)+1 bits, wrap-around; count-based full/empty.
  - FWFT: `out_data` and `out_flags` are valid in the same cycle `out_valid` rises, which is the cycle after the push edge.
  - Pop when empty is ignored.
  - Simultaneous push and pop while non-full and non-empty keeps the count unchanged.
  - `out_data` holds its last value when empty.
- All arithmetic is unsigned on raw bit patterns. There are no internal fp adders.

Test Plan:
- K_LEN=4, `in_valid` held high, bench models `acc_result` = 32'h40A00000 (5.0) after 4th beat -> `in_ready` low for exactly 2 cycles; `acc_clr` pulses 1 cycle after capture; `out_data` = 16'h40A0, `out_flags` = 0.
- Rounding, `relu_en`=0:
  - 32'h3F808000 -> 16'h3F80 (tie, even).
  - 32'h3F818000 -> 16'h3F82 (tie, odd rounds up).
  - 32'h3F808001 -> 16'h3F81.
  - 32'h7F7FFFFF -> 16'h7F80, `out_flags` = 01.
- Specials:
  - 32'h7FC00000 with `relu_en`=1 -> 16'h7FC0, flags = 10.
  - 32'hC0400000 with `relu_en`=1 -> 16'h0000.
  - 32'h80000001 with `relu_en`=0 -> 16'h8000.
- Backpressure: DEPTH=4, `out_ready`=0, run 5 vectors:
  - After 4 vectors, `fifo_full`=1; 5th vector stalls in CAPTURE with `in_ready`=0 and `acc_clr`=0.
  - Raise `out_ready` one cycle -> 5th written next cycle.
  - Popped order matches push order; no loss.
- Simultaneous push/pop with 2 entries held -> count stays 2; head advances correctly across pointer wrap after 9+ vectors.
- Assert `rst` asynchronously mid-ACCUM (`beat_cnt`=2) and while FIFO holds 3 entries -> outputs go to reset values immediately without a clock edge; next vector needs a full K_LEN beats.

Source files
------------

// File: rtl/bf_mac_drain.sv
// ---------------------------------------------------------------------------
// bf_mac_drain
//
// Sits downstream of a bfloat16 MAC PE. It gates the PE's mac_en so that
// exactly K_LEN products are accumulated. It then captures the fp32
// accumulator and rounds it to bf16 (round-to-nearest-even, optional ReLU).
// The result is pushed into a first-word-fall-through output FIFO. A
// one-cycle clear is pulsed back to the PE so the next dot product starts
// from zero.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   in_valid    upstream has an operand pair for the PE
//   in_ready    drain accepts a beat (PE mac_en = in_valid & in_ready)
//   acc_result  registered fp32 accumulator from the PE
//   relu_en     clamp negative results to +0; sampled in CAPTURE
//   acc_clr     one-cycle clear pulse to the PE
//   out_valid   FIFO non-empty
//   out_ready   consumer pops when out_valid & out_ready
//   out_data    bf16 result at the FIFO head (holds last value when empty)
//   out_flags   [1] NaN, [0] +/-inf for the head entry
//   fifo_full   FIFO holds DEPTH entries
//   beat_cnt    beats accepted in the current dot product
// ---------------------------------------------------------------------------
module bf_mac_drain #(
    parameter int K_LEN = 16,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [31:0]                  acc_result,
    input  logic                         relu_en,
    output logic                         acc_clr,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [15:0]                  out_data,
    output logic [1:0]                   out_flags,
    output logic                         fifo_full,
    output logic [$clog2(K_LEN+1)-1:0]   beat_cnt
);

    localparam int CW = $clog2(K_LEN + 1);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_ACCUM,
        ST_CAPTURE,
        ST_CLEAR
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push;

    // -----------------------------------------------------------------------
    // fp32 -> bf16 conversion (only consumed while in CAPTURE)
    // -----------------------------------------------------------------------
    logic        sign;
    logic        exp_all_ones;
    logic        exp_zero;
    logic        is_nan;
    logic        round_up;
    logic [15:0] conv_data;
    logic [1:0]  conv_flags;

    assign sign         = acc_result[31];
    assign exp_all_ones = (acc_result[30:23] == 8'hFF);
    assign exp_zero     = (acc_result[30:23] == 8'h00);
    assign is_nan       = exp_all_ones && (acc_result[22:0] != 23'h0);

    // Carry out of the low half of acc_result + 0x7FFF + acc_result[16].
    // It is set when the discarded half exceeds 0x8000, or equals 0x8000
    // with an odd kept LSB. That is round-to-nearest-even.
    assign round_up = acc_result[15] && ((acc_result[14:0] != 15'h0) || acc_result[16]);

    always_comb begin
        // NOTE: every output of a combinational block gets a value before any
        // branch, so no path can leave it unassigned and infer a latch.
        conv_data  = acc_result[31:16] + 16'(round_up);
        conv_flags = 2'b00;
        if (is_nan) begin
            conv_data  = 16'h7FC0;
            conv_flags = 2'b10;
        end else if (exp_all_ones) begin
            conv_data  = {sign, 8'hFF, 7'h00};
            conv_flags = 2'b01;
        end else if (exp_zero) begin
            conv_data  = {sign, 15'h0000};
        end else if (conv_data[14:7] == 8'hFF) begin
            // Rounding carried into an all-ones exponent. The mantissa is
            // already zero, so the result is a proper infinity.
            conv_flags = 2'b01;
        end
        // ReLU clamps every negative non-NaN value, including -0 and -inf.
        if (relu_en && !is_nan && sign) begin
            conv_data  = 16'h0000;
            conv_flags = 2'b00;
        end
    end

    // -----------------------------------------------------------------------
    // FIFO status, derived from the registered pointers
    // -----------------------------------------------------------------------
    logic [AW:0]  wr_ptr_q, rd_ptr_q;
    logic [AW:0]  fill;
    logic         pop;
    logic [17:0]  mem_q [DEPTH];
    logic [17:0]  head;
    logic [17:0]  hold_q;

    assign fill      = wr_ptr_q - rd_ptr_q;
    assign fifo_full = (fill == (AW+1)'(DEPTH));
    assign out_valid = (fill != '0);
    assign pop       = out_valid && out_ready;
    assign head      = mem_q[rd_ptr_q[AW-1:0]];

    // -----------------------------------------------------------------------
    // Control FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_ACCUM;
            cnt_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment. All
            // registers then update together from the pre-edge values,
            // regardless of statement order.
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        push     = 1'b0;
        in_ready = 1'b0;
        acc_clr  = 1'b0;
        case (state_q)
            ST_ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    cnt_d = cnt_q + CW'(1);
                    // The PE registers the last product at this same edge.
                    if (cnt_q == CW'(K_LEN - 1)) begin
                        state_d = ST_CAPTURE;
                    end
                end
            end
            ST_CAPTURE: begin
                // Space is judged on the registered fill only. A pop in this
                // cycle frees a slot from the next cycle on.
                if (!fifo_full) begin
                    push    = 1'b1;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                acc_clr = 1'b1;
                cnt_d   = '0;
                state_d = ST_ACCUM;
            end
            default: begin
                state_d = ST_ACCUM;
                cnt_d   = '0;
            end
        endcase
    end

    assign beat_cnt = cnt_q;

    // -----------------------------------------------------------------------
    // FIFO storage and pointers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            hold_q   <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
                hold_q   <= head;
            end
        end
    end

    // NOTE: the storage array has no reset. Only entries between the
    // pointers are ever observed, and emptying the FIFO is done by resetting
    // the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {conv_flags, conv_data};
        end
    end

    // When empty, show the last popped entry, or zero after reset.
    assign out_data  = out_valid ? head[15:0]  : hold_q[15:0];
    assign out_flags = out_valid ? head[17:16] : hold_q[17:16];

endmodule
